// File: rtl/aes_pkg.sv
// aes_pkg: shared constants, FSM state encoding and GF(2^8) helpers for the
// iterative AES-128 decryption engine.
//   AES_NUM_ROUNDS : number of AES-128 rounds (10)
//   AES_BLOCK_W    : block / round-key width in bits (128)
//   inv_state_e    : engine FSM states IDLE, ROUND, FINAL, DONE
//   gf_xtime       : multiply by x (0x02) modulo 0x11B
//   gf_mul         : general GF(2^8) multiply built from an xtime chain
package aes_pkg;

  localparam int AES_NUM_ROUNDS = 10;
  localparam int AES_BLOCK_W    = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } inv_state_e;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = gf_xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/inv_mix_column.sv
// inv_mix_column: combinational InvMixColumns on one 32-bit column.
//   col   : input column, a0 in bits [31:24] .. a3 in bits [7:0]
//   mixed : out_i = 0e*a_i ^ 0b*a_(i+1) ^ 0d*a_(i+2) ^ 09*a_(i+3)
module inv_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col,
  output logic [31:0] mixed
);

  logic [7:0] a  [4];
  logic [7:0] x2 [4];
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];
  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];

  // Each constant multiple is assembled from the x, x^2, x^3 terms of one
  // xtime chain per byte: 09 = 8+1, 0b = 8+2+1, 0d = 8+4+1, 0e = 8+4+2.
  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign a[i]  = col[31-8*i -: 8];
    assign x2[i] = gf_xtime(a[i]);
    assign x4[i] = gf_xtime(x2[i]);
    assign x8[i] = gf_xtime(x4[i]);
    assign m9[i] = x8[i] ^ a[i];
    assign mb[i] = x8[i] ^ x2[i] ^ a[i];
    assign md[i] = x8[i] ^ x4[i] ^ a[i];
    assign me[i] = x8[i] ^ x4[i] ^ x2[i];
  end

  for (genvar i = 0; i < 4; i++) begin : g_out
    assign mixed[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
  end

endmodule

// File: rtl/inv_s_box_16.sv
// inv_s_box_16: sixteen parallel AES inverse S-boxes (InvSubBytes on a block).
//   state  : 128-bit input block
//   subbed : 128-bit output, each byte replaced by InvSBox(byte)
// The inverse S-box is computed as the inverse affine map followed by the
// multiplicative inverse in GF(2^8) (0 maps to 0).
module inv_s_box_16
  import aes_pkg::*;
(
  input  logic [127:0] state,
  output logic [127:0] subbed
);

  // x^254 = x^-1 for x != 0, and 0 for x == 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction

  // Inverse affine: b = rotl(s,1) ^ rotl(s,3) ^ rotl(s,6) ^ 0x05.
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  for (genvar k = 0; k < 16; k++) begin : g_sbox
    assign subbed[8*k +: 8] = inv_sbox(state[8*k +: 8]);
  end

endmodule

// File: rtl/inv_round_engine.sv
// inv_round_engine: iterative AES-128 decryption, one shared round per cycle,
// 11 cycles per block (initial AddRoundKey, 9 full rounds, final round).
//   clk       : system clock, rising edge
//   n_rst     : asynchronous active-low reset
//   abort     : (only with INV_ROUND_ABORT_EN) drop the block in flight
//   start     : decrypt cipher_in; sampled only in IDLE
//   cipher_in : ciphertext, byte 0 = bits [127:120], column-major
//   round_key : round key for index key_round, combinational from key store
//   key_round : requested round-key index (10 IDLE, cnt ROUND, 0 FINAL/DONE)
//   busy      : high in ROUND and FINAL
//   done      : one-cycle pulse, plain_out valid
//   plain_out : state register, held until the next accepted start
// Optional feature macro: INV_ROUND_ABORT_EN.
//
// Handshake: start is a request accepted on any rising edge where the engine
// is IDLE and start=1; it is ignored (not queued) otherwise. There is no
// backpressure on the result: done pulses for exactly one cycle and the
// consumer must take plain_out then or any time before the next accepted start.
module inv_round_engine
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   n_rst,
`ifdef INV_ROUND_ABORT_EN
  input  logic                   abort,
`endif
  input  logic                   start,
  input  logic [AES_BLOCK_W-1:0] cipher_in,
  input  logic [AES_BLOCK_W-1:0] round_key,
  output logic [3:0]             key_round,
  output logic                   busy,
  output logic                   done,
  output logic [AES_BLOCK_W-1:0] plain_out
);

  inv_state_e             state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [AES_BLOCK_W-1:0] blk_q, blk_d;

  logic [AES_BLOCK_W-1:0] shifted;
  logic [AES_BLOCK_W-1:0] subbed;
  logic [AES_BLOCK_W-1:0] ark;
  logic [AES_BLOCK_W-1:0] mixed;

  // InvShiftRows: byte (r, c) of the output comes from byte (r, c-r mod 4).
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign shifted[127-8*(r+4*c) -: 8] = blk_q[127-8*(r+4*((c-r+4)%4)) -: 8];
    end
  end

  inv_s_box_16 u_inv_s_box_16 (
    .state  (shifted),
    .subbed (subbed)
  );

  assign ark = subbed ^ round_key;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    inv_mix_column u_inv_mix_column (
      .col   (ark[127-32*c -: 32]),
      .mixed (mixed[127-32*c -: 32])
    );
  end

  assign plain_out = blk_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    blk_d     = blk_q;
    key_round = 4'd0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        key_round = 4'(AES_NUM_ROUNDS);
        if (start) begin
          blk_d   = cipher_in ^ round_key;
          cnt_d   = 4'(AES_NUM_ROUNDS - 1);
          state_d = ROUND;
        end
      end
      ROUND: begin
        busy      = 1'b1;
        key_round = cnt_q;
        blk_d     = mixed;
        cnt_d     = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = FINAL;
      end
      FINAL: begin
        // Last round skips InvMixColumns; cnt_q is 0 here so key 0 is used.
        busy      = 1'b1;
        key_round = 4'd0;
        blk_d     = ark;
        state_d   = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef INV_ROUND_ABORT_EN
    if (abort && (state_q == ROUND || state_q == FINAL)) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      blk_d   = '0;
    end
`endif
  end

endmodule
